// File: rtl/dot3_pkg.sv
// Shared types and constants for the 3x3 matrix-vector sequencer and its dot-product unit.
package dot3_pkg;

    localparam int DOT3_LATENCY = 3;
    localparam logic [31:0] FP_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } seq_state_t;

    typedef struct packed {
        logic       v;
        logic [1:0] row;
    } tag_t;

endpackage

// File: rtl/dotProduct_3.sv
// Three-term signed dot product, fixed three-cycle latency, no reset (results are qualified externally).
module dotProduct_3 #(
    parameter int WIDTH       = 32,
    parameter int FIXED_POINT = 1
) (
    input  logic                 clk_i,
    input  logic [3*WIDTH-1:0]   a_i,
    input  logic [3*WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]     dot_o
);

    // Full-width product, then either the fixed-point middle slice (arith shift) or the low word.
    function automatic logic [WIDTH-1:0] mul_term(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] full;
        full = $signed(a) * $signed(b);
        if (FIXED_POINT != 0) return full[WIDTH/2 +: WIDTH];
        else return full[WIDTH-1:0];
    endfunction

    logic [3*WIDTH-1:0] a_q, b_q, term, prod_q;
    logic [WIDTH-1:0]   dot_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_term
            assign term[gi*WIDTH +: WIDTH] = mul_term(a_q[gi*WIDTH +: WIDTH], b_q[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        a_q    <= a_i;
        b_q    <= b_i;
        prod_q <= term;
        dot_q  <= prod_q[0 +: WIDTH] + prod_q[WIDTH +: WIDTH] + prod_q[2*WIDTH +: WIDTH];
    end

    assign dot_o = dot_q;

endmodule

// File: rtl/mat3_vec_sequencer.sv
// out = M * v computed one row per cycle on a shared dotProduct_3, with valid/ready on both sides.
module mat3_vec_sequencer
    import dot3_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FIXED_POINT = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*WIDTH-1:0]   mat_in,
    input  logic [3*WIDTH-1:0]   vec_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_x,
    output logic [WIDTH-1:0]     out_y,
    output logic [WIDTH-1:0]     out_z,
    output logic                 busy
);

    seq_state_t                     state_q, state_d;
    logic [1:0]                     row_cnt_q, row_cnt_d;
    logic [9*WIDTH-1:0]             mat_q;
    logic [3*WIDTH-1:0]             vec_q;
    tag_t [DOT3_LATENCY-1:0]        tag_q;
    tag_t                           push_tag, exit_tag;
    logic [WIDTH-1:0]               collect_q [3];
    logic [WIDTH-1:0]               out_x_q, out_y_q, out_z_q, out_x_d, out_y_d, out_z_d;
    logic                           out_valid_q, out_valid_d;
    logic [3*WIDTH-1:0]             row_sel;
    logic [WIDTH-1:0]               dot_out;
    logic                           accept, issue, row2_done, load_drain, load_hold;

    assign exit_tag  = tag_q[DOT3_LATENCY-1];
    assign row2_done = exit_tag.v && (exit_tag.row == 2'd2);
    assign push_tag  = {issue, row_cnt_q};

    always_comb begin
        case (row_cnt_q)
            2'd0:    row_sel = mat_q[0 +: 3*WIDTH];
            2'd1:    row_sel = mat_q[3*WIDTH +: 3*WIDTH];
            default: row_sel = mat_q[6*WIDTH +: 3*WIDTH];
        endcase
    end

    dotProduct_3 #(
        .WIDTH       (WIDTH),
        .FIXED_POINT (FIXED_POINT)
    ) u_dot (
        .clk_i (clk_in),
        .a_i   (row_sel),
        .b_i   (vec_q),
        .dot_o (dot_out)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            ISSUE:   if (row_cnt_q == 2'd2) state_d = DRAIN;
            DRAIN:   if (row2_done) state_d = (!out_valid_q || out_ready) ? IDLE : HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        busy       = (state_q != IDLE);
        accept     = (state_q == IDLE) && in_valid;
        issue      = (state_q == ISSUE);
        load_drain = (state_q == DRAIN) && row2_done && (!out_valid_q || out_ready);
        load_hold  = (state_q == HOLD) && out_ready;
    end

    // Row 2 is still in flight when the drain load happens, so it bypasses the collect register.
    always_comb begin
        row_cnt_d   = row_cnt_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        out_valid_d = out_valid_q;
        if (accept)     row_cnt_d = 2'd0;
        else if (issue) row_cnt_d = (row_cnt_q == 2'd2) ? 2'd0 : row_cnt_q + 2'd1;
        if (load_drain) begin
            out_x_d     = collect_q[0];
            out_y_d     = collect_q[1];
            out_z_d     = dot_out;
            out_valid_d = 1'b1;
        end else if (load_hold) begin
            out_x_d     = collect_q[0];
            out_y_d     = collect_q[1];
            out_z_d     = collect_q[2];
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_cnt_q   <= '0;
            mat_q       <= '0;
            vec_q       <= '0;
            tag_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_valid_q <= 1'b0;
            for (int r = 0; r < 3; r++) collect_q[r] <= '0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            tag_q       <= {tag_q[DOT3_LATENCY-2:0], push_tag};
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                mat_q <= mat_in;
                vec_q <= vec_in;
            end
            for (int r = 0; r < 3; r++) begin
                if (exit_tag.v && (exit_tag.row == r[1:0])) collect_q[r] <= dot_out;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

endmodule

// File: tb/tb_mat3_vec_sequencer.sv
// Directed scoreboard bench: one fixed-point and one integer sequencer share the same stimulus.
module tb_mat3_vec_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [287:0] mat;
    logic [95:0]  vec;

    logic        rdy_f, ov_f, busy_f, rdy_i, ov_i, busy_i;
    logic [31:0] x_f, y_f, z_f, x_i, y_i, z_i;

    int total = 0;
    int bad   = 0;
    logic [95:0] q_f[$];
    logic [95:0] q_i[$];

    always #5 clk = ~clk;

    mat3_vec_sequencer #(.WIDTH(32), .FIXED_POINT(1)) u_fp (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(rdy_f),
        .mat_in(mat), .vec_in(vec), .out_valid(ov_f), .out_ready(out_ready),
        .out_x(x_f), .out_y(y_f), .out_z(z_f), .busy(busy_f));

    mat3_vec_sequencer #(.WIDTH(32), .FIXED_POINT(0)) u_int (
        .clk_in(clk), .rst_in(rst), .in_valid(in_valid), .in_ready(rdy_i),
        .mat_in(mat), .vec_in(vec), .out_valid(ov_i), .out_ready(out_ready),
        .out_x(x_i), .out_y(y_i), .out_z(z_i), .busy(busy_i));

    function automatic logic [287:0] mkm(input logic [31:0] m00, m01, m02, m10, m11, m12, m20, m21, m22);
        return {m22, m21, m20, m12, m11, m10, m02, m01, m00};
    endfunction

    function automatic logic [95:0] mkv(input logic [31:0] v0, v1, v2);
        return {v2, v1, v0};
    endfunction

    function automatic logic [31:0] dot_m(input logic [95:0] r, input logic [95:0] v, input bit fp);
        logic [31:0] acc;
        longint      p;
        acc = 32'd0;
        for (int c = 0; c < 3; c++) begin
            p = longint'($signed(r[c*32 +: 32])) * longint'($signed(v[c*32 +: 32]));
            if (fp) p = p >>> 16;
            acc = acc + p[31:0];
        end
        return acc;
    endfunction

    function automatic logic [95:0] model(input logic [287:0] m, input logic [95:0] v, input bit fp);
        return {dot_m(m[192 +: 96], v, fp), dot_m(m[96 +: 96], v, fp), dot_m(m[0 +: 96], v, fp)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_front(input string tag);
        logic [95:0] e_f, e_i;
        total++;
        if (q_f.size() == 0 || q_i.size() == 0) begin
            bad++;
            $error("FAIL %s_empty observed=none expected=queued_result", tag);
        end else begin
            e_f = q_f.pop_front();
            e_i = q_i.pop_front();
            chk({tag, "_fx"}, x_f, e_f[31:0]);
            chk({tag, "_fy"}, y_f, e_f[63:32]);
            chk({tag, "_fz"}, z_f, e_f[95:64]);
            chk({tag, "_ix"}, x_i, e_i[31:0]);
            chk({tag, "_iy"}, y_i, e_i[63:32]);
            chk({tag, "_iz"}, z_i, e_i[95:64]);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic send(input logic [287:0] m, input logic [95:0] v, input bit push);
        int n;
        n = 0;
        in_valid = 1'b1;
        mat = m;
        vec = v;
        while (!rdy_f && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, rdy_f}, 32'd1);
        if (push) begin
            q_f.push_back(model(m, v, 1'b1));
            q_i.push_back(model(m, v, 1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 1;
        while (!ov_f && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, ov_f}, 32'd1);
        chk({tag, "_valid_int"}, {31'd0, ov_i}, 32'd1);
        check_front(tag);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, {30'd0, ov_f, ov_i}, 32'd0);
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [95:0] held_f, held_i;
        logic [287:0] m2;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mat = '0;
        vec = '0;
        repeat (2) @(negedge clk);
        chk("rst_ovalid", {30'd0, ov_f, ov_i}, 32'd0);
        chk("rst_busy", {30'd0, busy_f, busy_i}, 32'd0);
        chk("rst_ready", {30'd0, rdy_f, rdy_i}, 32'd3);
        chk("rst_x", x_f | y_f | z_f | x_i | y_i | z_i, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Identity in Q16.16, latency measurement
        send(mkm(32'h10000, 0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000),
             mkv(32'h18000, 32'hFFFE0000, 32'h30000), 1'b1);
        wait_out("t1", lat);
        chk("t1_latency", lat, 32'd7);
        chk("t1_x_lit", x_f, 32'h18000);
        chk("t1_y_lit", y_f, 32'hFFFE0000);
        chk("t1_z_lit", z_f, 32'h30000);
        consume("t1");

        // Integer rows, two vectors
        m2 = mkm(1, 2, 3, 4, 5, 6, 7, 8, 9);
        send(m2, mkv(1, 1, 1), 1'b1);
        wait_out("t2a", lat);
        chk("t2a_y_lit", y_i, 32'd15);
        consume("t2a");
        send(m2, mkv(32'hFFFFFFFF, 0, 2), 1'b1);
        wait_out("t2b", lat);
        chk("t2b_x_lit", x_i, 32'd5);
        consume("t2b");

        // Backpressure: second result parks in HOLD
        send(mkm(2, 0, 1, 0, 3, 0, 1, 1, 1), mkv(32'h20000, 5, 32'hFFFF0000), 1'b1);
        held_f = model(mkm(2, 0, 1, 0, 3, 0, 1, 1, 1), mkv(32'h20000, 5, 32'hFFFF0000), 1'b1);
        held_i = model(mkm(2, 0, 1, 0, 3, 0, 1, 1, 1), mkv(32'h20000, 5, 32'hFFFF0000), 1'b0);
        wait_out("t3a", lat);
        send(mkm(5, 6, 7, 8, 9, 10, 11, 12, 13), mkv(32'h30000, 32'hFFFFFFFE, 4), 1'b1);
        repeat (7) @(negedge clk);
        chk("t3_hold_ready", {31'd0, rdy_f}, 32'd0);
        chk("t3_hold_busy", {31'd0, busy_f}, 32'd1);
        chk("t3_hold_valid", {31'd0, ov_f}, 32'd1);
        chk("t3_hold_fx", x_f, held_f[31:0]);
        chk("t3_hold_iz", z_i, held_i[95:64]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t3_reload_valid", {31'd0, ov_f}, 32'd1);
        chk("t3_reload_idle", {30'd0, busy_f, rdy_f}, 32'd1);
        check_front("t3b");
        consume("t3b");

        // Reset during A+4 discards in-flight work
        send(mkm(1, 1, 1, 1, 1, 1, 1, 1, 1), mkv(3, 3, 3), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t4_ovalid", {30'd0, ov_f, ov_i}, 32'd0);
        chk("t4_busy", {30'd0, busy_f, busy_i}, 32'd0);
        chk("t4_ready", {30'd0, rdy_f, rdy_i}, 32'd3);
        chk("t4_outs", x_f | y_f | z_f | x_i | y_i | z_i, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ov_f || ov_i) seen = 1'b1;
        end
        chk("t4_no_stale", {31'd0, seen}, 32'd0);

        // Signed wrap in integer mode
        send(mkm(32'h7FFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0), mkv(1, 1, 0), 1'b1);
        wait_out("t5", lat);
        chk("t5_wrap_lit", x_i, 32'h80000000);
        consume("t5");

        // in_valid held with changing data: only the accepted set counts
        send(mkm(3, 1, 4, 1, 5, 9, 2, 6, 5), mkv(32'h10000, 2, 32'hFFFFFFFD), 1'b1);
        in_valid = 1'b1;
        for (int k = 1; k < 6; k++) begin
            mat = ~mat;
            vec = vec + 96'd7;
            if (k == 2) chk("t6_busy_ready", {30'd0, busy_f, rdy_f}, 32'd2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_out("t6", lat);
        consume("t6");
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov_f || ov_i || busy_f) seen = 1'b1;
        end
        chk("t6_single", {31'd0, seen}, 32'd0);
        chk("sb_empty", q_f.size() + q_i.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
